// File: rtl/scrypt_pkg.sv
// Shared definitions for the scrypt BlockMix control path: state encoding,
// default sizing and the index helpers used by the sequencer and its counters.
package scrypt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_XOR   = 3'd2,
        ST_ROUND = 3'd3,
        ST_STORE = 3'd4,
        ST_DONE  = 3'd5
    } bm_state_t;

    localparam int DEFAULT_R            = 1;
    localparam int DEFAULT_SALSA_ROUNDS = 8;

    // Width of an index over n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // BlockMix output interleave: even sub-blocks fill the low half of Y,
    // odd sub-blocks fill the high half.
    function automatic int store_slot(input int i, input int r);
        return ((i % 2) == 0) ? (i / 2) : (r + (i - 1) / 2);
    endfunction

endpackage

// File: rtl/blockmix_ct_if.sv
// Handshake and datapath-control bundle between ROMix, the BlockMix
// sequencer and the BlockMix datapath.
interface blockmix_ct_if #(parameter int IDX_W = 1);

    logic             blockmix_en;
    logic             blockmix_valid;
    logic             busy;
    logic             load_x;
    logic             xor_en;
    logic             round_en;
    logic             store_en;
    logic [IDX_W-1:0] sub_idx;
    logic [IDX_W-1:0] store_idx;

    modport master (
        output blockmix_en,
        input  blockmix_valid, busy, load_x, xor_en, round_en, store_en,
               sub_idx, store_idx
    );

    modport slave (
        input  blockmix_en,
        output blockmix_valid, busy, load_x, xor_en, round_en, store_en,
               sub_idx, store_idx
    );

endinterface

// File: rtl/blockmix_ct_step_ctr.sv
// Sub-block and double-round counters for the BlockMix sequencer, each with
// a terminal-count flag the FSM uses to leave ROUND and STORE.
module blockmix_step_ctr
    import scrypt_pkg::*;
#(
    parameter  int SUBS  = 2,
    parameter  int DR    = 4,
    localparam int SUB_W = idx_width(SUBS),
    localparam int RND_W = idx_width(DR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sub_clr,
    input  logic             sub_inc,
    input  logic             rnd_clr,
    input  logic             rnd_inc,
    output logic [SUB_W-1:0] sub_cnt,
    output logic             sub_last,
    output logic             rnd_last
);

    logic [RND_W-1:0] rnd_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_cnt <= '0;
            rnd_cnt <= '0;
        end else begin
            if (sub_clr)
                sub_cnt <= '0;
            else if (sub_inc)
                sub_cnt <= sub_cnt + SUB_W'(1);

            if (rnd_clr)
                rnd_cnt <= '0;
            else if (rnd_inc)
                rnd_cnt <= rnd_cnt + RND_W'(1);
        end
    end

    assign sub_last = (sub_cnt == SUB_W'(SUBS - 1));
    assign rnd_last = (rnd_cnt == RND_W'(DR - 1));

endmodule

// File: rtl/blockmix_ct.sv
// BlockMix_Salsa20/8 control sequencer: walks the datapath through load,
// per-sub-block xor / double-rounds / feed-forward store, then a done pulse.
//
//   state | meaning
//   IDLE  | waiting for blockmix_en
//   LOAD  | X <- B[2R-1]
//   XOR   | X, T <- X ^ B[sub_idx]
//   ROUND | one Salsa double-round on T per cycle
//   STORE | X <- X + T, Y[store_idx] <- X + T
//   DONE  | one-cycle blockmix_valid, then back to IDLE
module blockmix_ct
    import scrypt_pkg::*;
#(
    parameter int R            = DEFAULT_R,
    parameter int SALSA_ROUNDS = DEFAULT_SALSA_ROUNDS
) (
    input  logic         clk,
    input  logic         reset,
    blockmix_ct_if.slave bm
);

    localparam int SUBS  = 2 * R;
    localparam int DR    = SALSA_ROUNDS / 2;
    localparam int IDX_W = idx_width(SUBS);

    if (R < 1 || SALSA_ROUNDS < 2 || (SALSA_ROUNDS % 2) != 0) begin : g_param_err
        $error("blockmix_ct: R must be >= 1 and SALSA_ROUNDS even and >= 2");
    end

    bm_state_t        state;
    bm_state_t        state_nxt;
    logic             sub_clr;
    logic             sub_inc;
    logic             rnd_clr;
    logic             rnd_inc;
    logic [IDX_W-1:0] sub_cnt;
    logic             sub_last;
    logic             rnd_last;

    blockmix_step_ctr #(
        .SUBS (SUBS),
        .DR   (DR)
    ) u_step_ctr (
        .clk      (clk),
        .reset    (reset),
        .sub_clr  (sub_clr),
        .sub_inc  (sub_inc),
        .rnd_clr  (rnd_clr),
        .rnd_inc  (rnd_inc),
        .sub_cnt  (sub_cnt),
        .sub_last (sub_last),
        .rnd_last (rnd_last)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sub_clr   = 1'b0;
        sub_inc   = 1'b0;
        rnd_clr   = 1'b0;
        rnd_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bm.blockmix_en)
                    state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                sub_clr   = 1'b1;
                state_nxt = ST_XOR;
            end
            ST_XOR: begin
                rnd_clr   = 1'b1;
                state_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                if (rnd_last)
                    state_nxt = ST_STORE;
                else
                    rnd_inc = 1'b1;
            end
            ST_STORE: begin
                if (sub_last) begin
                    state_nxt = ST_DONE;
                end else begin
                    sub_inc   = 1'b1;
                    state_nxt = ST_XOR;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        // Request withdrawn mid-run: abandon the block; DONE already finished.
        if (!bm.blockmix_en && state != ST_IDLE && state != ST_DONE)
            state_nxt = ST_IDLE;
    end

    always_comb begin
        bm.busy           = (state != ST_IDLE);
        bm.load_x         = (state == ST_LOAD);
        bm.xor_en         = (state == ST_XOR);
        bm.round_en       = (state == ST_ROUND);
        bm.store_en       = (state == ST_STORE);
        bm.blockmix_valid = (state == ST_DONE);
        bm.sub_idx        = '0;
        if (state == ST_XOR || state == ST_ROUND || state == ST_STORE)
            bm.sub_idx = sub_cnt;
        bm.store_idx      = IDX_W'(store_slot(int'(bm.sub_idx), R));
    end

endmodule

// File: tb/tb_blockmix_ct.sv
// Directed bench for blockmix_ct with one R=1 and one R=2 instance.
module tb_blockmix_ct;
    import scrypt_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    blockmix_ct_if #(.IDX_W(1)) b1 ();
    blockmix_ct_if #(.IDX_W(2)) b2 ();

    blockmix_ct #(.R(1), .SALSA_ROUNDS(8)) dut1 (.clk(clk), .reset(reset), .bm(b1.slave));
    blockmix_ct #(.R(2), .SALSA_ROUNDS(8)) dut2 (.clk(clk), .reset(reset), .bm(b2.slave));

    function automatic int pack(int valid, int load, int xr, int rnd, int st, int busy,
                                int sub, int sidx);
        return valid | (load << 1) | (xr << 2) | (rnd << 3) | (st << 4) | (busy << 5)
               | (sub << 8) | (sidx << 12);
    endfunction

    // Expected outputs k cycles after blockmix_en was first sampled in IDLE.
    function automatic int exp_pack(int k, int r, int dr);
        int per;
        int last;
        int j;
        int i;
        int m;
        int sl;
        per  = dr + 2;
        last = 2 + 2 * r * per;
        if (k < 1 || k > last) return 0;
        if (k == 1)    return pack(0, 1, 0, 0, 0, 1, 0, 0);
        if (k == last) return pack(1, 0, 0, 0, 0, 1, 0, 0);
        j  = k - 2;
        i  = j / per;
        m  = j % per;
        sl = ((i % 2) == 0) ? i / 2 : r + (i - 1) / 2;
        if (m == 0)  return pack(0, 0, 1, 0, 0, 1, i, sl);
        if (m <= dr) return pack(0, 0, 0, 1, 0, 1, i, sl);
        return pack(0, 0, 0, 0, 1, 1, i, sl);
    endfunction

    function automatic int obs1();
        return pack(int'(b1.blockmix_valid), int'(b1.load_x), int'(b1.xor_en),
                    int'(b1.round_en), int'(b1.store_en), int'(b1.busy),
                    int'(b1.sub_idx), int'(b1.store_idx));
    endfunction

    function automatic int obs2();
        return pack(int'(b2.blockmix_valid), int'(b2.load_x), int'(b2.xor_en),
                    int'(b2.round_en), int'(b2.store_en), int'(b2.busy),
                    int'(b2.sub_idx), int'(b2.store_idx));
    endfunction

    task automatic chk(input string tag, input int o, input int e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rounds;
        int valids;
        int loads;
        int n;
        int slots [4];

        reset = 1'b1;
        b1.blockmix_en = 1'b0;
        b2.blockmix_en = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("reset_r1", obs1(), 0);
        chk("reset_r2", obs2(), 0);
        reset = 1'b0;
        step();
        chk("post_reset_r1", obs1(), 0);
        chk("post_reset_r2", obs2(), 0);

        // Single R=1 run, request dropped right after the done pulse.
        b1.blockmix_en = 1'b1;
        rounds = 0;
        valids = 0;
        for (int k = 1; k <= 14; k++) begin
            step();
            chk("run1_seq", obs1(), exp_pack(k, 1, 4));
            rounds += int'(b1.round_en);
            valids += int'(b1.blockmix_valid);
            if (k == 7)  chk("run1_t7_store",  int'({b1.store_en, b1.store_idx}), 2);
            if (k == 13) chk("run1_t13_store", int'({b1.store_en, b1.store_idx}), 3);
            if (k == 14) chk("run1_t14_valid", int'(b1.blockmix_valid), 1);
        end
        step();
        b1.blockmix_en = 1'b0;
        chk("run1_t15_idle", obs1(), 0);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("run1_quiet", obs1(), 0);
            valids += int'(b1.blockmix_valid);
        end
        chk("run1_round_cycles", rounds, 8);
        chk("run1_valid_count", valids, 1);

        // Request held for 40 cycles: back-to-back runs with a 15-cycle period.
        b1.blockmix_en = 1'b1;
        valids = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            chk("b2b_seq", obs1(), exp_pack(k % 15, 1, 4));
            valids += int'(b1.blockmix_valid);
            if (k == 14 || k == 29) chk("b2b_valid_pulse", int'(b1.blockmix_valid), 1);
        end
        chk("b2b_valid_count", valids, 2);
        b1.blockmix_en = 1'b0;
        step();
        chk("b2b_abort_idle", obs1(), 0);
        step();
        chk("b2b_abort_quiet", obs1(), 0);

        // R=2 run: interleaved store slots 0,2,1,3 and valid at T0+26.
        b2.blockmix_en = 1'b1;
        loads = 0;
        n = 0;
        for (int k = 1; k <= 26; k++) begin
            step();
            chk("r2_seq", obs2(), exp_pack(k, 2, 4));
            loads += int'(b2.load_x);
            if (b2.store_en && n < 4) begin
                slots[n] = int'(b2.store_idx);
                n++;
            end
            if (k == 26) chk("r2_t26_valid", int'(b2.blockmix_valid), 1);
        end
        chk("r2_store_count", n, 4);
        chk("r2_slot0", slots[0], 0);
        chk("r2_slot1", slots[1], 2);
        chk("r2_slot2", slots[2], 1);
        chk("r2_slot3", slots[3], 3);
        chk("r2_load_count", loads, 1);
        step();
        b2.blockmix_en = 1'b0;
        chk("r2_t27_idle", obs2(), 0);
        step();
        chk("r2_quiet", obs2(), 0);

        // Reset during ROUND at T5, then a full run with the request still high.
        b1.blockmix_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("rst_pre_seq", obs1(), exp_pack(k, 1, 4));
        end
        reset = 1'b1;
        step();
        chk("rst_t6_zero", obs1(), 0);
        reset = 1'b0;
        valids = 0;
        for (int k = 1; k <= 14; k++) begin
            step();
            chk("rst_rerun_seq", obs1(), exp_pack(k, 1, 4));
            valids += int'(b1.blockmix_valid);
        end
        chk("rst_rerun_valid_count", valids, 1);
        step();
        b1.blockmix_en = 1'b0;
        chk("rst_rerun_idle", obs1(), 0);

        // Request withdrawn at T9: nothing after the abort cycle.
        b1.blockmix_en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("abort_pre_seq", obs1(), exp_pack(k, 1, 4));
        end
        b1.blockmix_en = 1'b0;
        for (int k = 10; k <= 16; k++) begin
            step();
            chk("abort_idle", obs1(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
